// File: rtl/clock_enable_scheduler.sv
// rtl/clock_enable_scheduler.sv - processor clock-enable sequencer (halt / run / single-step)
//
// Purpose: issues a registered one-cycle CLK_EN qualifier to the processor core.
//   HALT : no enables.
//   RUN  : one enable every div_reg+1 cycles.
//   STEP : one enable per rising edge of the debug step button.
// Ports:
//   CLK_IN    in   1      system clock, rising edge
//   RST       in   1      synchronous active-high reset
//   MODE      in   2      01 RUN, 10 STEP, 00/11 HALT
//   STEP_REQ  in   1      debounced step button level
//   HALT_REQ  in   1      processor halt request level
//   DIV_LOAD  in   1      load DIV_VAL into divisor this cycle
//   DIV_VAL   in   CNT_W  new divisor (period = DIV_VAL+1)
//   CLK_EN    out  1      one-cycle enable pulse
//   RUNNING   out  1      high while in S_RUN
//   TICK_CNT  out  16     number of CLK_EN pulses issued (wrapping)
module clock_enable_scheduler #(
    parameter int          CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             STEP_REQ,
    input  logic             HALT_REQ,
    input  logic             DIV_LOAD,
    input  logic [CNT_W-1:0] DIV_VAL,
    output logic             CLK_EN,
    output logic             RUNNING,
    output logic [15:0]      TICK_CNT
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_clk_en;
    logic             w_next_clk_en;
    logic             r_running;
    logic [15:0]      r_tick;
    logic             r_step_q;
    logic             w_step_edge;

    // r_step_q resets high so a button held through reset is not seen as a press.
    assign w_step_edge = STEP_REQ & ~r_step_q;

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_clk_en = 1'b0;
        case (r_state)
            S_HALT: begin
                if (MODE == MODE_RUN && !HALT_REQ) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end else if (MODE == MODE_STEP && w_step_edge) begin
                    w_next_state = S_STEP;
                end
            end
            S_RUN: begin
                // Leaving RUN takes priority over a terminal count: no pulse on exit.
                if (MODE != MODE_RUN || HALT_REQ) begin
                    w_next_state = S_HALT;
                    w_next_cnt   = '0;
                end else if (r_cnt == r_div) begin
                    w_next_cnt    = '0;
                    w_next_clk_en = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_STEP: begin
                w_next_clk_en = 1'b1;
                w_next_state  = S_HALT;
            end
            default: begin
                w_next_state = S_HALT;
            end
        endcase
        // A divisor load restarts the period; in RUN it also suppresses a
        // coincident terminal-count pulse. A step pulse is unaffected.
        if (DIV_LOAD) begin
            w_next_cnt = '0;
            if (r_state == S_RUN) begin
                w_next_clk_en = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_state   <= S_HALT;
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_clk_en  <= 1'b0;
            r_running <= 1'b0;
            r_tick    <= '0;
            r_step_q  <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            if (DIV_LOAD) begin
                r_div <= DIV_VAL;
            end
            r_clk_en  <= w_next_clk_en;
            r_running <= (w_next_state == S_RUN);
            r_tick    <= r_tick + 16'(r_clk_en);
            r_step_q  <= STEP_REQ;
        end
    end

    assign CLK_EN   = r_clk_en;
    assign RUNNING  = r_running;
    assign TICK_CNT = r_tick;

endmodule
